// File: rtl/dft_reorder_buf.sv
// rtl/dft_reorder_buf.sv - ping-pong reorder buffer: out-of-order DFT bins in, natural-order stream out
// Two banks fill by data_index and drain in fill order through a 2-entry skid buffer.
module dft_reorder_buf #(
    parameter int OUT_WIDTH = 16,
    parameter int MAX_LEN   = 2048
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic                 block_sync_i,
    input  logic                 data_val_i,
    input  logic [OUT_WIDTH-1:0] data_real_i,
    input  logic [OUT_WIDTH-1:0] data_imag_i,
    input  logic [10:0]          data_index_i,
    input  logic [11:0]          trans_len_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_sync_o,
    output logic                 out_last_o,
    output logic [OUT_WIDTH-1:0] out_real_o,
    output logic [OUT_WIDTH-1:0] out_imag_o,
    output logic [10:0]          out_index_o,
    output logic [11:0]          out_len_o,
    output logic                 drop_o,
    output logic                 runt_o
);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_st_t;
    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN} rd_st_t;

    typedef struct packed {
        logic [2*OUT_WIDTH-1:0] data;
        logic [10:0]            index;
        logic [11:0]            len;
        logic                   sync;
        logic                   last;
    } ent_t;

    logic [2*OUT_WIDTH-1:0] mem_a [MAX_LEN];
    logic [2*OUT_WIDTH-1:0] mem_b [MAX_LEN];
    logic [2*OUT_WIDTH-1:0] ram_a_q, ram_b_q;

    bank_st_t    bank_st_q [2];
    bank_st_t    bank_st_d [2];
    logic [11:0] bank_len_q [2];
    logic [11:0] bank_len_d [2];
    logic        wr_active_q, wr_active_d;
    logic        wr_bank_q, wr_bank_d;
    logic [11:0] wr_cnt_q, wr_cnt_d;
    logic        older_q, older_d;
    logic        drop_q, drop_d;
    logic        runt_q, runt_d;

    rd_st_t      rd_st_q, rd_st_d;
    logic        rd_bank_q, rd_bank_d;
    logic [11:0] rd_len_q, rd_len_d;
    logic [10:0] rd_addr_q, rd_addr_d;
    logic        p_valid_q, p_valid_d;
    logic        p_bank_q, p_bank_d;
    logic [10:0] p_index_q, p_index_d;
    logic [11:0] p_len_q, p_len_d;
    logic [1:0]  occ_q, occ_d;
    ent_t        e0_q, e0_d, e1_q, e1_d;

    logic        empty_a, empty_b, claim_bank;
    logic        we, we_bank, mark_full, full_bank;
    logic [11:0] cur_wlen;
    logic        full_a, full_b, sel_bank, start, credit, pop;
    logic        cur_bank;
    logic [11:0] cur_len;
    logic [10:0] cur_addr;
    logic [2:0]  occ_ext;
    ent_t        p_ent;

    assign out_valid_o = (occ_q != 2'd0);
    assign out_sync_o  = e0_q.sync;
    assign out_last_o  = e0_q.last;
    assign out_real_o  = e0_q.data[2*OUT_WIDTH-1:OUT_WIDTH];
    assign out_imag_o  = e0_q.data[OUT_WIDTH-1:0];
    assign out_index_o = e0_q.index;
    assign out_len_o   = e0_q.len;
    assign drop_o      = drop_q;
    assign runt_o      = runt_q;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        bank_st_d   = bank_st_q;
        bank_len_d  = bank_len_q;
        wr_active_d = wr_active_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        older_d     = older_q;
        drop_d      = 1'b0;
        runt_d      = 1'b0;
        empty_a     = (bank_st_q[0] == BANK_EMPTY);
        empty_b     = (bank_st_q[1] == BANK_EMPTY);
        claim_bank  = 1'b0;
        we          = 1'b0;
        we_bank     = wr_bank_q;
        cur_wlen    = bank_len_q[wr_bank_q];
        mark_full   = 1'b0;
        full_bank   = wr_bank_q;

        if (data_val_i && block_sync_i) begin
            // A truncated block frees its bank before the new block looks for one.
            if (wr_active_q) begin
                bank_st_d[wr_bank_q] = BANK_EMPTY;
                runt_d               = 1'b1;
                wr_active_d          = 1'b0;
                if (wr_bank_q) empty_b = 1'b1;
                else           empty_a = 1'b1;
            end
            if (trans_len_i == 12'd0 || trans_len_i > 12'(MAX_LEN)) begin
                drop_d = 1'b1;
            end else if (empty_a || empty_b) begin
                claim_bank             = !empty_a;
                wr_bank_d              = claim_bank;
                bank_len_d[claim_bank] = trans_len_i;
                wr_cnt_d               = 12'd1;
                we_bank                = claim_bank;
                cur_wlen               = trans_len_i;
                we                     = ({1'b0, data_index_i} < trans_len_i);
                if (trans_len_i == 12'd1) begin
                    mark_full = 1'b1;
                    full_bank = claim_bank;
                end else begin
                    bank_st_d[claim_bank] = BANK_FILLING;
                    wr_active_d           = 1'b1;
                end
            end else begin
                drop_d = 1'b1;
            end
        end else if (data_val_i && wr_active_q) begin
            we       = ({1'b0, data_index_i} < cur_wlen);
            wr_cnt_d = wr_cnt_q + 12'd1;
            if (wr_cnt_q + 12'd1 == cur_wlen) begin
                mark_full   = 1'b1;
                wr_active_d = 1'b0;
            end
        end

        if (mark_full) begin
            bank_st_d[full_bank] = BANK_FULL;
            older_d = (bank_st_q[!full_bank] == BANK_FULL) ? !full_bank : full_bank;
        end

        // Read side: an IDLE cycle that sees a FULL bank already issues address 0.
        full_a   = (bank_st_q[0] == BANK_FULL);
        full_b   = (bank_st_q[1] == BANK_FULL);
        sel_bank = (full_a && full_b) ? older_q : !full_a;
        start    = (rd_st_q == RD_IDLE) && (full_a || full_b);
        cur_bank = start ? sel_bank : rd_bank_q;
        cur_len  = start ? bank_len_q[sel_bank] : rd_len_q;
        cur_addr = start ? 11'd0 : rd_addr_q;
        occ_ext  = {1'b0, occ_q} + {2'b00, p_valid_q};
        credit   = pop ? (occ_ext <= 3'd2) : (occ_ext <= 3'd1);

        rd_st_d   = rd_st_q;
        rd_bank_d = rd_bank_q;
        rd_len_d  = rd_len_q;
        rd_addr_d = rd_addr_q;
        p_valid_d = 1'b0;
        p_bank_d  = p_bank_q;
        p_index_d = p_index_q;
        p_len_d   = p_len_q;

        if (start) begin
            rd_st_d   = RD_RUN;
            rd_bank_d = sel_bank;
            rd_len_d  = cur_len;
            rd_addr_d = 11'd0;
        end
        if ((start || rd_st_q == RD_RUN) && credit) begin
            p_valid_d = 1'b1;
            p_bank_d  = cur_bank;
            p_index_d = cur_addr;
            p_len_d   = cur_len;
            rd_addr_d = cur_addr + 11'd1;
            rd_st_d   = ({1'b0, cur_addr} == cur_len - 12'd1) ? RD_DRAIN : RD_RUN;
        end
        if (rd_st_q == RD_DRAIN && pop && e0_q.last) begin
            bank_st_d[rd_bank_q] = BANK_EMPTY;
            rd_st_d              = RD_IDLE;
        end

        p_ent.data  = p_bank_q ? ram_b_q : ram_a_q;
        p_ent.index = p_index_q;
        p_ent.len   = p_len_q;
        p_ent.sync  = (p_index_q == 11'd0);
        p_ent.last  = ({1'b0, p_index_q} == p_len_q - 12'd1);

        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({pop, p_valid_q})
            2'b01: begin
                if (occ_q == 2'd0) e0_d = p_ent;
                else               e1_d = p_ent;
                occ_d = occ_q + 2'd1;
            end
            2'b10: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = p_ent;
                end else begin
                    e0_d = e1_q;
                    e1_d = p_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (we && !we_bank) mem_a[data_index_i] <= {data_real_i, data_imag_i};
        if (we &&  we_bank) mem_b[data_index_i] <= {data_real_i, data_imag_i};
        ram_a_q <= mem_a[cur_addr];
        ram_b_q <= mem_b[cur_addr];
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            bank_st_q   <= '{default: BANK_EMPTY};
            bank_len_q  <= '{default: 12'd0};
            wr_active_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= 12'd0;
            older_q     <= 1'b0;
            drop_q      <= 1'b0;
            runt_q      <= 1'b0;
            rd_st_q     <= RD_IDLE;
            rd_bank_q   <= 1'b0;
            rd_len_q    <= 12'd0;
            rd_addr_q   <= 11'd0;
            p_valid_q   <= 1'b0;
            p_bank_q    <= 1'b0;
            p_index_q   <= 11'd0;
            p_len_q     <= 12'd0;
            occ_q       <= 2'd0;
            e0_q        <= '0;
            e1_q        <= '0;
        end else begin
            bank_st_q   <= bank_st_d;
            bank_len_q  <= bank_len_d;
            wr_active_q <= wr_active_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            older_q     <= older_d;
            drop_q      <= drop_d;
            runt_q      <= runt_d;
            rd_st_q     <= rd_st_d;
            rd_bank_q   <= rd_bank_d;
            rd_len_q    <= rd_len_d;
            rd_addr_q   <= rd_addr_d;
            p_valid_q   <= p_valid_d;
            p_bank_q    <= p_bank_d;
            p_index_q   <= p_index_d;
            p_len_q     <= p_len_d;
            occ_q       <= occ_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
        end
    end

endmodule

// File: tb/tb_dft_reorder_buf.sv
// tb/tb_dft_reorder_buf.sv - self-checking bench for dft_reorder_buf
// Expected stream is a queue of natural-order samples per accepted block.
module tb_dft_reorder_buf;
    localparam int W    = 16;
    localparam int MAXL = 2048;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          block_sync_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [W-1:0]  data_real_i = '0;
    logic [W-1:0]  data_imag_i = '0;
    logic [10:0]   data_index_i = '0;
    logic [11:0]   trans_len_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic          out_sync_o, out_last_o;
    logic [W-1:0]  out_real_o, out_imag_o;
    logic [10:0]   out_index_o;
    logic [11:0]   out_len_o;
    logic          drop_o, runt_o;

    dft_reorder_buf #(.OUT_WIDTH(W), .MAX_LEN(MAXL)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .block_sync_i(block_sync_i), .data_val_i(data_val_i),
        .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .data_index_i(data_index_i), .trans_len_i(trans_len_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sync_o(out_sync_o), .out_last_o(out_last_o),
        .out_real_o(out_real_o), .out_imag_o(out_imag_o),
        .out_index_o(out_index_o), .out_len_o(out_len_o),
        .drop_o(drop_o), .runt_o(runt_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int           idx;
        int           len;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int total = 0, bad = 0, cyc = 0;
    int pending = 0, hs_count = 0, drop_cnt = 0, runt_cnt = 0;
    int first_valid_cyc = -1, last_done_cyc = 0, sync_gap = 0, drv_cyc = 0, last_in_cyc = 0;
    int rdy_mode = 0;
    logic [W-1:0] first_re, last_re, last_im;
    logic [11:0]  last_len;
    logic         hold_v = 1'b0;
    logic [56:0]  hold_val;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(posedge clk_sys) begin
        #1;
        case (rdy_mode)
            0: out_ready_i = 1'b0;
            1: out_ready_i = 1'b1;
            2: out_ready_i = ~out_ready_i;
            default: out_ready_i = 1'($urandom_range(1, 0));
        endcase
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_sys) begin
            hold_v = 1'b0;
        end else begin
            if (drop_o) drop_cnt++;
            if (runt_o) runt_cnt++;
            if (hold_v) begin
                chk("hold_valid", out_valid_o, 1);
                chk("hold_fields", {out_real_o, out_imag_o, out_index_o, out_len_o, out_sync_o, out_last_o}, hold_val);
            end
            if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid_o && out_ready_i) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got index %0d, required no output", out_index_o);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("out_index", out_index_o, e_cur.idx);
                    chk("out_real", out_real_o, e_cur.re);
                    chk("out_imag", out_imag_o, e_cur.im);
                    chk("out_len", out_len_o, e_cur.len);
                    chk("out_sync", out_sync_o, (e_cur.idx == 0));
                    chk("out_last", out_last_o, (e_cur.idx == e_cur.len - 1));
                end
                hs_count++;
                if (out_sync_o) begin
                    first_re = out_real_o;
                    sync_gap = cyc - last_done_cyc;
                end
                if (out_last_o) begin
                    pending--;
                    last_done_cyc = cyc;
                    last_re  = out_real_o;
                    last_im  = out_imag_o;
                    last_len = out_len_o;
                end
            end else if (out_valid_o) begin
                hold_v   = 1'b1;
                hold_val = {out_real_o, out_imag_o, out_index_o, out_len_o, out_sync_o, out_last_o};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) if (v & (1 << b)) r |= 1 << (bits - 1 - b);
        return r;
    endfunction

    task automatic idle_cycle();
        @(posedge clk_sys); #1;
        data_val_i   = 1'b0;
        block_sync_i = 1'b0;
    endtask

    task automatic drive(input bit s, input int idx, input int len, input logic [W-1:0] re, input logic [W-1:0] im);
        @(posedge clk_sys); #1;
        block_sync_i = s;
        data_val_i   = 1'b1;
        data_index_i = 11'(idx);
        trans_len_i  = s ? 12'(len) : 12'($urandom);
        data_real_i  = re;
        data_imag_i  = im;
        drv_cyc      = cyc;
    endtask

    // order: 0 natural, 1 bit-reversed (16 points), 2 random permutation
    task automatic send_block(input int len, input int nsamp, input int order, input bit det,
                              input bit keep, input int gap_pct);
        int perm[MAXL];
        logic [W-1:0] re[MAXL];
        logic [W-1:0] im[MAXL];
        exp_t e;
        for (int i = 0; i < len; i++) begin
            perm[i] = i;
            re[i] = det ? W'(100 + i) : W'($urandom);
            im[i] = det ? W'(-i) : W'($urandom);
        end
        if (order == 1) begin
            for (int i = 0; i < len; i++) perm[i] = bitrev(i, 4);
        end else if (order == 2) begin
            for (int i = len - 1; i > 0; i--) begin
                int j = int'($urandom_range(i, 0));
                int t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
        end
        for (int k = 0; k < nsamp; k++) begin
            if (k > 0 && gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) idle_cycle();
            drive(k == 0, perm[k], len, re[perm[k]], im[perm[k]]);
        end
        last_in_cyc = drv_cyc;
        idle_cycle();
        if (keep) begin
            for (int i = 0; i < len; i++) begin
                e.idx = i; e.len = len; e.re = re[i]; e.im = im[i];
                exp_q.push_back(e);
            end
            pending++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_sys);
        chk("drain_remaining", exp_q.size(), 0);
        repeat (4) @(negedge clk_sys);
        chk("idle_after_drain", out_valid_o, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_sync"}, out_sync_o, 0);
        chk({tag, "_last"}, out_last_o, 0);
        chk({tag, "_drop"}, drop_o, 0);
        chk({tag, "_runt"}, runt_o, 0);
        chk({tag, "_real"}, out_real_o, 0);
        chk({tag, "_imag"}, out_imag_o, 0);
        chk({tag, "_index"}, out_index_o, 0);
        chk({tag, "_len"}, out_len_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, h0, i;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_zero_outputs("reset");
        @(posedge clk_sys); #1;
        rst_sys = 1'b0;

        // bit-reversed 16-point block, ready high, plus a stray sample afterwards
        rdy_mode = 1;
        first_valid_cyc = -1;
        send_block(16, 16, 1, 1, 1, 0);
        drive(0, 3, 0, 16'hdead, 16'hbeef);
        idle_cycle();
        wait_drain(200);
        chk("first_valid_latency", first_valid_cyc - last_in_cyc, 3);
        chk("block16_span", last_done_cyc - first_valid_cyc, 15);
        chk("lit_first_re", first_re, 100);
        chk("lit_last_re", last_re, 115);
        chk("lit_last_im", last_im, 16'hfff1);

        // 1200 points with toggling ready
        rdy_mode = 2;
        h0 = hs_count;
        send_block(1200, 1200, 2, 0, 1, 0);
        wait_drain(5000);
        chk("hs_1200", hs_count - h0, 1200);

        // both banks fill while stalled, third block dropped
        rdy_mode = 0;
        d0 = drop_cnt;
        send_block(12, 12, 2, 0, 1, 0);
        send_block(12, 12, 2, 0, 1, 0);
        rdy_mode = 1;
        send_block(12, 12, 2, 0, 0, 0);
        wait_drain(400);
        chk("drop_full_banks", drop_cnt - d0, 1);
        chk("block_gap_ok", (sync_gap <= 3), 1);

        // runt: 24-point block cut after 10 samples by a 36-point block
        d0 = drop_cnt;
        r0 = runt_cnt;
        send_block(24, 10, 2, 0, 0, 0);
        send_block(36, 36, 2, 0, 1, 0);
        wait_drain(400);
        chk("runt_count", runt_cnt - r0, 1);
        chk("runt_no_drop", drop_cnt - d0, 0);
        chk("runt_out_len", last_len, 36);

        // illegal lengths, then a full-size block
        d0 = drop_cnt;
        drive(1, 0, 0, 16'h1111, 16'h2222);
        drive(0, 1, 0, 16'h3333, 16'h4444);
        drive(0, 2, 0, 16'h5555, 16'h6666);
        idle_cycle();
        drive(1, 5, 4000, 16'h7777, 16'h8888);
        drive(0, 6, 0, 16'h9999, 16'haaaa);
        idle_cycle();
        repeat (10) @(negedge clk_sys);
        chk("drop_bad_len", drop_cnt - d0, 2);
        chk("no_out_bad_len", out_valid_o, 0);
        send_block(2048, 2048, 2, 0, 1, 0);
        wait_drain(6000);

        // reset in the middle of a 64-point output
        d0 = drop_cnt;
        r0 = runt_cnt;
        h0 = hs_count;
        send_block(64, 64, 2, 0, 1, 0);
        for (i = 0; i < 300 && hs_count < h0 + 20; i++) @(negedge clk_sys);
        chk("pre_reset_handshakes", (hs_count >= h0 + 20), 1);
        @(posedge clk_sys); #1;
        rst_sys = 1'b1;
        @(posedge clk_sys); #1;
        exp_q.delete();
        pending = 0;
        rst_sys = 1'b0;
        @(negedge clk_sys);
        check_zero_outputs("midrst");
        send_block(16, 16, 2, 0, 1, 0);
        wait_drain(300);
        chk("rst_no_drop", drop_cnt - d0, 0);
        chk("rst_no_runt", runt_cnt - r0, 0);

        // randomized blocks with random ready and input gaps
        rdy_mode = 3;
        d0 = drop_cnt;
        r0 = runt_cnt;
        for (int b = 0; b < 10; b++) begin
            int len;
            for (i = 0; i < 2000 && pending > 1; i++) @(negedge clk_sys);
            chk("rand_bank_free", (pending <= 1), 1);
            len = (b < 2) ? 1 : int'($urandom_range(80, 1));
            send_block(len, len, 2, 0, 1, 20);
        end
        wait_drain(5000);
        chk("rand_no_drop", drop_cnt - d0, 0);
        chk("rand_no_runt", runt_cnt - r0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
